// File: rtl/fixed_pt_vec_mul_pipe.sv
// Multi-lane signed Q-format multiplier: round/truncate, saturate/wrap, per-lane overflow flags.
// Latency PIPE_STAGES cycles from acceptance to out_valid; sustains one vector per clock.
// Backpressure: one global stall (advance = !out_valid || out_ready) freezes every stage; in_ready = advance.
module fixed_pt_vec_mul_pipe #(
  parameter int OPERAND_WIDTH = 24,
  parameter int DECIMAL_PLACE = 12,
  parameter int LANES         = 4,
  parameter int PIPE_STAGES   = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*OPERAND_WIDTH-1:0]   operand1,
  input  logic [LANES*OPERAND_WIDTH-1:0]   operand2,
  input  logic                             round_en,
  input  logic                             sat_en,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*OPERAND_WIDTH-1:0]   product,
  output logic [LANES-1:0]                 overflow
);

  localparam int W    = OPERAND_WIDTH;
  localparam int VW   = LANES * W;
  // One spare bit above the 2W-bit product absorbs the rounding addend safely.
  localparam int PW   = 2 * W + 1;
  // Stages after the operand register: the first holds the arithmetic result,
  // the rest are plain delay registers. PIPE_STAGES must be at least 2.
  localparam int NDLY = PIPE_STAGES - 1;

  localparam logic signed [PW-1:0] RND   = PW'(1) << (DECIMAL_PLACE - 1);
  localparam logic signed [PW-1:0] S_MAX = {{(W + 2){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [PW-1:0] S_MIN = {{(W + 2){1'b1}}, {(W - 1){1'b0}}};
  localparam logic [W-1:0]         R_MAX = {1'b0, {(W - 1){1'b1}}};
  localparam logic [W-1:0]         R_MIN = {1'b1, {(W - 1){1'b0}}};

  logic            advance;
  logic            s1_valid;
  logic [VW-1:0]   s1_a;
  logic [VW-1:0]   s1_b;
  logic            s1_round;
  logic            s1_sat;

  logic [VW-1:0]    arith_res;
  logic [LANES-1:0] arith_ovf;

  logic [NDLY-1:0]  d_valid;
  logic [VW-1:0]    d_res [NDLY];
  logic [LANES-1:0] d_ovf [NDLY];

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = d_valid[NDLY-1];
  assign product   = d_res[NDLY-1];
  assign overflow  = d_ovf[NDLY-1];

  // Operand/mode capture: modes are latched with their operands so they travel together.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_round <= 1'b0;
      s1_sat   <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_a     <= operand1;
      s1_b     <= operand2;
      s1_round <= round_en;
      s1_sat   <= sat_en;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [W-1:0]  a;
    logic signed [W-1:0]  b;
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] p_full;
    logic signed [PW-1:0] p_rnd;
    logic signed [PW-1:0] p_shf;
    logic                 lane_ovf;

    assign a        = s1_a[i*W +: W];
    assign b        = s1_b[i*W +: W];
    assign a_ext    = {{(W + 1){a[W-1]}}, a};
    assign b_ext    = {{(W + 1){b[W-1]}}, b};
    assign p_full   = a_ext * b_ext;
    assign p_rnd    = s1_round ? (p_full + RND) : p_full;
    assign p_shf    = p_rnd >>> DECIMAL_PLACE;
    // Range check happens after rounding, so a rounding carry past max counts as overflow.
    assign lane_ovf = (p_shf > S_MAX) || (p_shf < S_MIN);

    assign arith_ovf[i]          = lane_ovf;
    assign arith_res[i*W +: W]   = (lane_ovf && s1_sat) ? (p_shf[PW-1] ? R_MIN : R_MAX)
                                                        : p_shf[W-1:0];
  end

  // Result register followed by delay stages; all shift together on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NDLY; k++) begin
        d_valid[k] <= 1'b0;
        d_res[k]   <= '0;
        d_ovf[k]   <= '0;
      end
    end else if (advance) begin
      d_valid[0] <= s1_valid;
      d_res[0]   <= arith_res;
      d_ovf[0]   <= arith_ovf;
      for (int k = 1; k < NDLY; k++) begin
        d_valid[k] <= d_valid[k-1];
        d_res[k]   <= d_res[k-1];
        d_ovf[k]   <= d_ovf[k-1];
      end
    end
  end

endmodule
